sram_responder: RTL and testbench

Synthesizable responder for the DS2064-style asynchronous SRAM pin interface: it sits on the far side of the SRAM pins from the SRAM controller and behaves as the chip. It decodes chip-enable, write-enable and output-enable, holds an 8K×8 array, drives read data after a programmable access latency, and commits writes on the trailing edge of the write pulse. It replaces the physical DS2064 in simulation and FPGA self-test builds, and optionally flags pin-protocol violations.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_responder_mem.sv | 32 +++
 rtl/sram_responder.sv | 166 ++++++++++++++++
 tb/tb_sram_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and sizes for the SRAM pin-level responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 13;
    localparam int unsigned SRAM_DATA_W = 8;
    localparam int unsigned ACC_CNT_W   = 4;   // holds ACCESS_CYCLES-1 for 1..15
    localparam int unsigned WE_CNT_W    = 4;   // write-pulse length, saturates at 15
    localparam int unsigned TXN_CNT_W   = 16;  // read/write transaction counters

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_READ_ACCESS = 2'd1,
        ST_READ_VALID  = 2'd2,
        ST_WRITE       = 2'd3
    } sram_state_e;

    // Saturating increment for the transaction counters.
    function automatic logic [TXN_CNT_W-1:0] sat_inc(input logic [TXN_CNT_W-1:0] v);
        return (v == '1) ? v : v + TXN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// Single-port synchronous RAM: one write port, registered read-first output.
// Latency: read data appears one clk edge after the address is presented.
// Backpressure: none; accepts an access every cycle.
//
// Ports: clk; we_i/addr_i/wdata_i write and read share the one address;
// rdata_o is the registered read of addr_i. Contents are never reset.
module sram_responder_mem #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Behaves as a DS2064-style async SRAM chip behind its pins: decodes CE/WE/OE, holds the array.
// Latency: read data valid after the ACCESS_CYCLES-th edge sampling a read; write commits on trailing WE edge.
// Backpressure: none; the pin protocol has no handshake, the controller times its own accesses.
//
// Ports: clk, n_reset (async active-low); sram_address/sram_data_in/n_ce1/ce2/n_we/n_oe are the
// chip pins; sram_data_out/sram_data_oe drive the data pins back; read_count/write_count are
// saturating transaction counters; err_contention/err_short_we are sticky protocol flags that
// exist only when SRAM_RESPONDER_CHECKS_EN is defined (otherwise tied low).
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W        = SRAM_ADDR_W,
    parameter int unsigned DATA_W        = SRAM_DATA_W,
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned MIN_WE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [ADDR_W-1:0]    sram_address,
    input  logic [DATA_W-1:0]    sram_data_in,
    output logic [DATA_W-1:0]    sram_data_out,
    output logic                 sram_data_oe,
    input  logic                 n_ce1,
    input  logic                 ce2,
    input  logic                 n_we,
    input  logic                 n_oe,
    output logic [TXN_CNT_W-1:0] read_count,
    output logic [TXN_CNT_W-1:0] write_count,
    output logic                 err_contention,
    output logic                 err_short_we
);

    // Edges still needed after the first RD edge; zero means data is valid on that edge.
    localparam logic [ACC_CNT_W-1:0] ACC_LOAD = ACC_CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [WE_CNT_W-1:0]  WE_MIN   = WE_CNT_W'(MIN_WE_CYCLES);

    logic selected;
    logic wr;
    logic rd;

    assign selected = !n_ce1 && ce2;
    assign wr       = selected && !n_we;
    assign rd       = selected && n_we && !n_oe;

    sram_state_e           state_q;
    logic [ACC_CNT_W-1:0]  acc_cnt_q;
    logic [WE_CNT_W-1:0]   we_cnt_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic                  oe_q;
    logic [TXN_CNT_W-1:0]  rd_cnt_q;
    logic [TXN_CNT_W-1:0]  wr_cnt_q;

    // Trailing edge of the write pulse: WR no longer sampled while in WRITE.
    logic wr_end;
    logic pulse_ok;
    logic commit_d;

    assign wr_end   = (state_q == ST_WRITE) && !wr;
    assign pulse_ok = (we_cnt_q >= WE_MIN);
    assign commit_d = wr_end && pulse_ok;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // The single RAM port reads the live pins except on the commit edge.
    assign ram_addr = commit_d ? wr_addr_q : sram_address;

    sram_responder_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (commit_d),
        .addr_i  (ram_addr),
        .wdata_i (wr_data_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            acc_cnt_q <= '0;
            we_cnt_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            oe_q      <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else if (wr) begin
            // WR wins from any state; the last sampled address/data is what commits.
            state_q   <= ST_WRITE;
            oe_q      <= 1'b0;
            wr_addr_q <= sram_address;
            wr_data_q <= sram_data_in;
            if (state_q != ST_WRITE) begin
                we_cnt_q <= WE_CNT_W'(1);
            end else if (we_cnt_q != '1) begin
                we_cnt_q <= we_cnt_q + WE_CNT_W'(1);
            end
        end else if (state_q == ST_WRITE) begin
            // Short pulses are dropped silently; the array write itself is commit_d.
            if (commit_d) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
            state_q <= ST_IDLE;
        end else if (!rd) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
        end else if (state_q == ST_IDLE || sram_address != rd_addr_q) begin
            // New access, or an address change restarting one in progress.
            rd_addr_q <= sram_address;
            if (ACC_LOAD == '0) begin
                state_q  <= ST_READ_VALID;
                oe_q     <= 1'b1;
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end else begin
                state_q   <= ST_READ_ACCESS;
                oe_q      <= 1'b0;
                acc_cnt_q <= ACC_LOAD;
            end
        end else if (state_q == ST_READ_ACCESS) begin
            if (acc_cnt_q == ACC_CNT_W'(1)) begin
                state_q  <= ST_READ_VALID;
                oe_q     <= 1'b1;
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            acc_cnt_q <= acc_cnt_q - ACC_CNT_W'(1);
        end
        // READ_VALID at an unchanged address holds; the RAM output re-reads every edge.
    end

    // A real chip tri-states as soon as WE falls, so the driver is also gated by the live pins.
    assign sram_data_oe  = oe_q && !wr;
    assign sram_data_out = oe_q ? ram_rdata : '0;
    assign read_count    = rd_cnt_q;
    assign write_count   = wr_cnt_q;

`ifdef SRAM_RESPONDER_CHECKS_EN
    logic err_cont_q;
    logic err_short_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            err_cont_q  <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            if (selected && !n_we && !n_oe) begin
                err_cont_q <= 1'b1;
            end
            if (wr_end && !pulse_ok) begin
                err_short_q <= 1'b1;
            end
        end
    end

    assign err_contention = err_cont_q;
    assign err_short_we   = err_short_q;
`else
    assign err_contention = 1'b0;
    assign err_short_we   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

    localparam int A1 = 1;
    localparam int M1 = 1;
    localparam int A3 = 3;
    localparam int M3 = 2;

`ifdef SRAM_RESPONDER_CHECKS_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset;
    logic [12:0] sram_address;
    logic [7:0]  sram_data_in;
    logic        n_ce1, ce2, n_we, n_oe;

    logic [7:0]  d1_dat, d3_dat;
    logic        d1_oe, d3_oe;
    logic [15:0] d1_rc, d1_wc, d3_rc, d3_wc;
    logic        d1_ec, d1_es, d3_ec, d3_es;

    always #5 clk = ~clk;

    sram_responder #(.ACCESS_CYCLES(A1), .MIN_WE_CYCLES(M1)) u_dut1 (
        .clk(clk), .n_reset(n_reset), .sram_address(sram_address), .sram_data_in(sram_data_in),
        .sram_data_out(d1_dat), .sram_data_oe(d1_oe), .n_ce1(n_ce1), .ce2(ce2), .n_we(n_we),
        .n_oe(n_oe), .read_count(d1_rc), .write_count(d1_wc), .err_contention(d1_ec),
        .err_short_we(d1_es)
    );

    sram_responder #(.ACCESS_CYCLES(A3), .MIN_WE_CYCLES(M3)) u_dut3 (
        .clk(clk), .n_reset(n_reset), .sram_address(sram_address), .sram_data_in(sram_data_in),
        .sram_data_out(d3_dat), .sram_data_oe(d3_oe), .n_ce1(n_ce1), .ce2(ce2), .n_we(n_we),
        .n_oe(n_oe), .read_count(d3_rc), .write_count(d3_wc), .err_contention(d3_ec),
        .err_short_we(d3_es)
    );

    // Reference model: array contents per instance (only addresses ever written) and counters.
    logic [7:0] m1 [int];
    logic [7:0] m3 [int];
    int exp_rc1, exp_rc3, exp_wc1, exp_wc3;
    bit exp_ec, exp_es3;
    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_idle();
        n_ce1 = 1'b1; ce2 = 1'b0; n_we = 1'b1; n_oe = 1'b1;
    endtask

    task automatic rd_start(input int a);
        sram_address = 13'(a);
        n_ce1 = 1'b0; ce2 = 1'b1; n_we = 1'b1; n_oe = 1'b0;
    endtask

    task automatic model_reset();
        exp_rc1 = 0; exp_rc3 = 0; exp_wc1 = 0; exp_wc3 = 0;
        exp_ec = 1'b0; exp_es3 = 1'b0;
    endtask

    // Drives a write pulse of len sampled edges, then the trailing edge, and updates the model.
    task automatic wr_op(input int a, input logic [7:0] d, input int len);
        sram_address = 13'(a); sram_data_in = d;
        n_ce1 = 1'b0; ce2 = 1'b1; n_we = 1'b0; n_oe = 1'b1;
        repeat (len) tick();
        drv_idle();
        tick();
        if (len >= M1) begin m1[a] = d; exp_wc1++; end
        if (len >= M3) begin m3[a] = d; exp_wc3++; end
        else exp_es3 = 1'b1;
    endtask

    task automatic test_reset();
        drv_idle();
        sram_address = '0; sram_data_in = '0;
        n_reset = 1'b0;
        model_reset();
        tick(); tick();
        total++; if ({d1_dat, d3_dat} !== 16'h0) begin bad++; $display("FAIL reset_dat: got %h want 0000", {d1_dat, d3_dat}); end
        total++; if ({d1_oe, d3_oe} !== 2'b00) begin bad++; $display("FAIL reset_oe: got %b want 00", {d1_oe, d3_oe}); end
        total++; if ({d1_rc, d1_wc, d3_rc, d3_wc} !== 64'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", {d1_rc, d1_wc, d3_rc, d3_wc}); end
        total++; if ({d1_ec, d1_es, d3_ec, d3_es} !== 4'b0) begin bad++; $display("FAIL reset_err: got %b want 0000", {d1_ec, d1_es, d3_ec, d3_es}); end
        n_reset = 1'b1;
    endtask

    task automatic test_first_read();
        rd_start(0);
        tick();
        exp_rc1++;
        total++; if (d1_oe !== 1'b1) begin bad++; $display("FAIL first_oe1: got %b want 1", d1_oe); end
        total++; if (d1_rc !== 16'(exp_rc1)) begin bad++; $display("FAIL first_rc1: got %0d want %0d", d1_rc, exp_rc1); end
        total++; if (d3_oe !== 1'b0) begin bad++; $display("FAIL first_oe3_early: got %b want 0", d3_oe); end
        tick(); tick();
        exp_rc3++;
        total++; if (d3_oe !== 1'b1 || d3_rc !== 16'(exp_rc3)) begin bad++; $display("FAIL first_oe3: got oe=%b rc=%0d want oe=1 rc=%0d", d3_oe, d3_rc, exp_rc3); end
        drv_idle(); tick();
        total++; if ({d1_oe, d3_oe} !== 2'b00) begin bad++; $display("FAIL first_oe_drop: got %b want 00", {d1_oe, d3_oe}); end
    endtask

    task automatic test_write_read();
        wr_op('h1234, 8'hA5, 3);
        total++; if (d1_wc !== 16'(exp_wc1) || d3_wc !== 16'(exp_wc3)) begin bad++; $display("FAIL wr_count: got %0d/%0d want %0d/%0d", d1_wc, d3_wc, exp_wc1, exp_wc3); end
        rd_start('h1234);
        tick(); tick(); tick();
        exp_rc1++; exp_rc3++;
        total++; if (d1_dat !== 8'hA5 || d3_dat !== 8'hA5) begin bad++; $display("FAIL wr_rd_dat: got %h/%h want a5", d1_dat, d3_dat); end
        drv_idle(); tick();
    endtask

    task automatic test_addr_change();
        logic [7:0] d;
        d = 8'($urandom);
        wr_op('h1FFF, 8'h3C, 3);
        wr_op('h0001, d, 2);
        rd_start('h1FFF);
        tick(); tick(); tick();
        exp_rc1++; exp_rc3++;
        total++; if (d1_dat !== 8'h3C || d3_dat !== 8'h3C) begin bad++; $display("FAIL ac_first: got %h/%h want 3c", d1_dat, d3_dat); end
        sram_address = 13'h0001;
        for (int k = 1; k <= A3; k++) begin
            tick();
            total++; if (d1_oe !== 1'b1 || d1_dat !== m1[1]) begin bad++; $display("FAIL ac_d1 k=%0d: got oe=%b dat=%h want oe=1 dat=%h", k, d1_oe, d1_dat, m1[1]); end
            total++; if (d3_oe !== (k >= A3)) begin bad++; $display("FAIL ac_oe3 k=%0d: got %b want %b", k, d3_oe, k >= A3); end
        end
        exp_rc1++; exp_rc3++;
        total++; if (d3_dat !== m3[1]) begin bad++; $display("FAIL ac_d3: got %h want %h", d3_dat, m3[1]); end
        total++; if (d1_rc !== 16'(exp_rc1) || d3_rc !== 16'(exp_rc3)) begin bad++; $display("FAIL ac_rc: got %0d/%0d want %0d/%0d", d1_rc, d3_rc, exp_rc1, exp_rc3); end
        drv_idle(); tick();
        rd_start('h1FFF);
        tick(); tick(); tick();
        exp_rc1++; exp_rc3++;
        total++; if (d1_dat !== 8'h3C || d3_dat !== 8'h3C) begin bad++; $display("FAIL ac_keep: got %h/%h want 3c", d1_dat, d3_dat); end
        drv_idle(); tick();
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        logic [7:0] d;
        a1 = 'h0800; a2 = 'h0801; d = 8'($urandom);
        rd_start(a1);
        tick(); tick(); tick();
        exp_rc1++; exp_rc3++;
        total++; if ({d1_oe, d3_oe} !== 2'b11) begin bad++; $display("FAIL b2b_rd_oe: got %b want 11", {d1_oe, d3_oe}); end
        // Read straight into write: drivers must let go as soon as WE falls.
        sram_address = 13'(a2); sram_data_in = d; n_we = 1'b0; n_oe = 1'b1;
        #1;
        total++; if ({d1_oe, d3_oe} !== 2'b00) begin bad++; $display("FAIL b2b_oe_we: got %b want 00", {d1_oe, d3_oe}); end
        tick(); tick();
        total++; if ({d1_oe, d3_oe} !== 2'b00) begin bad++; $display("FAIL b2b_wr_oe: got %b want 00", {d1_oe, d3_oe}); end
        m1[a2] = d; m3[a2] = d; exp_wc1++; exp_wc3++;
        // Write straight into read: trailing edge, then a fresh access.
        rd_start(a2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (d1_oe !== (k >= 1 + A1) || d3_oe !== (k >= 1 + A3)) begin bad++; $display("FAIL b2b_wr_rd_oe k=%0d: got %b%b want %b%b", k, d1_oe, d3_oe, k >= 1 + A1, k >= 1 + A3); end
        end
        exp_rc1++; exp_rc3++;
        total++; if (d1_dat !== d || d3_dat !== d) begin bad++; $display("FAIL b2b_dat: got %h/%h want %h", d1_dat, d3_dat, d); end
        drv_idle(); tick();
    endtask

    task automatic test_contention();
        int a;
        logic [7:0] d;
        a = 'h0A5A; d = 8'($urandom);
        sram_address = 13'(a); sram_data_in = d;
        n_ce1 = 1'b0; ce2 = 1'b1; n_we = 1'b0; n_oe = 1'b0;
        tick(); tick();
        exp_ec = 1'b1;
        total++; if ({d1_oe, d3_oe} !== 2'b00) begin bad++; $display("FAIL cont_oe: got %b want 00", {d1_oe, d3_oe}); end
        total++; if (d1_ec !== (CHK & exp_ec) || d3_ec !== (CHK & exp_ec)) begin bad++; $display("FAIL cont_flag: got %b%b want %b", d1_ec, d3_ec, CHK & exp_ec); end
        drv_idle(); tick();
        m1[a] = d; m3[a] = d; exp_wc1++; exp_wc3++;
        rd_start(a);
        tick(); tick(); tick();
        exp_rc1++; exp_rc3++;
        total++; if (d1_dat !== d || d3_dat !== d) begin bad++; $display("FAIL cont_commit: got %h/%h want %h", d1_dat, d3_dat, d); end
        drv_idle(); tick();
    endtask

    task automatic test_random();
        int pool [8];
        pool[0] = 0; pool[1] = 'h1FFF;
        for (int i = 2; i < 8; i++) pool[i] = int'($urandom_range(2, 'h1FFE));
        for (int n = 0; n < 40; n++) begin
            int a;
            int len;
            logic [7:0] d;
            a = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                len = int'($urandom_range(1, 3));
                wr_op(a, d, len);
            end else begin
                rd_start(a);
                for (int k = 1; k <= A3; k++) begin
                    tick();
                    total++; if (d1_oe !== (k >= A1) || d3_oe !== (k >= A3)) begin bad++; $display("FAIL rnd_oe k=%0d: got %b%b want %b%b", k, d1_oe, d3_oe, k >= A1, k >= A3); end
                end
                exp_rc1++; exp_rc3++;
                if (m1.exists(a)) begin
                    total++; if (d1_dat !== m1[a]) begin bad++; $display("FAIL rnd_dat1 @%h: got %h want %h", a, d1_dat, m1[a]); end
                end
                if (m3.exists(a)) begin
                    total++; if (d3_dat !== m3[a]) begin bad++; $display("FAIL rnd_dat3 @%h: got %h want %h", a, d3_dat, m3[a]); end
                end
                drv_idle(); tick();
            end
        end
        total++; if (d1_rc !== 16'(exp_rc1) || d3_rc !== 16'(exp_rc3)) begin bad++; $display("FAIL rnd_rc: got %0d/%0d want %0d/%0d", d1_rc, d3_rc, exp_rc1, exp_rc3); end
        total++; if (d1_wc !== 16'(exp_wc1) || d3_wc !== 16'(exp_wc3)) begin bad++; $display("FAIL rnd_wc: got %0d/%0d want %0d/%0d", d1_wc, d3_wc, exp_wc1, exp_wc3); end
        total++; if (d1_es !== 1'b0 || d3_es !== (CHK & exp_es3)) begin bad++; $display("FAIL rnd_short: got %b%b want 0%b", d1_es, d3_es, CHK & exp_es3); end
        // A 1-edge pulse always commits at MIN 1 and never at MIN 2.
        wr_op('h0333, 8'h96, 1);
        rd_start('h0333);
        tick(); tick(); tick();
        exp_rc1++; exp_rc3++;
        total++; if (d1_dat !== 8'h96) begin bad++; $display("FAIL short_commit1: got %h want 96", d1_dat); end
        total++; if (d3_wc !== 16'(exp_wc3) || d3_es !== CHK) begin bad++; $display("FAIL short_drop3: got wc=%0d es=%b want wc=%0d es=%b", d3_wc, d3_es, exp_wc3, CHK); end
        drv_idle(); tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] old;
        old = 8'($urandom);
        wr_op('h0010, old, 3);
        // Reset during a write pulse: pending write is lost.
        sram_address = 13'h0010; sram_data_in = 8'h55;
        n_ce1 = 1'b0; ce2 = 1'b1; n_we = 1'b0; n_oe = 1'b1;
        tick(); tick();
        #2 n_reset = 1'b0;
        model_reset();
        #1;
        total++; if (d1_wc !== 16'h0 || d3_wc !== 16'h0) begin bad++; $display("FAIL rstw_wc: got %0d/%0d want 0", d1_wc, d3_wc); end
        total++; if ({d1_ec, d1_es, d3_ec, d3_es} !== 4'b0) begin bad++; $display("FAIL rstw_err: got %b want 0000", {d1_ec, d1_es, d3_ec, d3_es}); end
        drv_idle();
        n_reset = 1'b1;
        tick();
        rd_start('h0010);
        tick(); tick(); tick();
        exp_rc1++; exp_rc3++;
        total++; if (d1_dat !== old || d3_dat !== old) begin bad++; $display("FAIL rstw_mem: got %h/%h want %h", d1_dat, d3_dat, old); end
        total++; if (d1_wc !== 16'(exp_wc1) || d1_rc !== 16'(exp_rc1)) begin bad++; $display("FAIL rstw_cnt: got wc=%0d rc=%0d want wc=%0d rc=%0d", d1_wc, d1_rc, exp_wc1, exp_rc1); end
        // Reset during a valid read: drivers drop without waiting for a clock edge.
        #2 n_reset = 1'b0;
        model_reset();
        #1;
        total++; if ({d1_oe, d3_oe} !== 2'b00 || {d1_dat, d3_dat} !== 16'h0) begin bad++; $display("FAIL rstr_oe: got oe=%b%b dat=%h%h want 00/0000", d1_oe, d3_oe, d1_dat, d3_dat); end
        drv_idle();
        n_reset = 1'b1;
        tick();
        total++; if (d1_rc !== 16'h0 || d3_rc !== 16'h0) begin bad++; $display("FAIL rstr_rc: got %0d/%0d want 0", d1_rc, d3_rc); end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_read();
        test_addr_change();
        test_back_to_back();
        test_contention();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
